// File: rtl/core_cp15_fault_log_pkg.sv
// Shared CP15 fault-log map: fault record layout, register selects, LOGSTAT bit
// positions and the MCR control bits of the LOGSTAT register.
package core_cp15_fault_log_pkg;

   // Architected FSR field widths carried in each history record.
   localparam int unsigned RecAddrW   = 30;
   localparam int unsigned RecStatusW = 4;
   localparam int unsigned RecDomainW = 4;

   typedef struct packed {
      logic [RecAddrW-1:0]   addr;
      logic [RecStatusW-1:0] status;
      logic [RecDomainW-1:0] domain;
      logic                  prefetch;
   } fault_rec_t;

   localparam int unsigned RecW = $bits(fault_rec_t);

   // Register selects
   localparam logic [1:0] SelFsr     = 2'd0;
   localparam logic [1:0] SelFar     = 2'd1;
   localparam logic [1:0] SelLogAddr = 2'd2;
   localparam logic [1:0] SelLogStat = 2'd3;

   // LOGSTAT layout
   localparam int unsigned LsValidBit    = 31;
   localparam int unsigned LsOvfBit      = 30;
   localparam int unsigned LsAddrNextBit = 29;
   localparam int unsigned LsCountLsb    = 16;
   localparam int unsigned LsPrefetchBit = 8;
   localparam int unsigned LsDomainLsb   = 4;
   localparam int unsigned LsStatusLsb   = 0;

   // MCR to LOGSTAT control bits
   localparam int unsigned PopBit    = 0;
   localparam int unsigned ClrOvfBit = 1;

endpackage

// File: rtl/core_cp15_fault_fifo.sv
// Overwrite-oldest history FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write a
// record at the tail (dropping the head when full); pop_i discards the head when
// non-empty; clr_ovf_i clears the sticky overflow flag (a same-cycle overflow
// wins); head_o is the head entry (stale when empty); count_o, full_o,
// overflow_o; nonempty_o is a registered copy of (count != 0).
module core_cp15_fault_fifo #(
   parameter  int unsigned Depth = 4,
   parameter  int unsigned Width = 8,
   localparam int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clr_ovf_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] head_o,
   output logic [CntW-1:0]  count_o,
   output logic             full_o,
   output logic             overflow_o,
   output logic             nonempty_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             nonempty_q;
   logic             full, do_pop;

   assign full   = (count_q == CntW'(Depth));
   assign do_pop = pop_i && (count_q != '0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clr_ovf_i) ovf_d = 1'b0;
      if (push_i) begin
         tail_d = tail_q + PtrW'(1);
         if (do_pop) begin
            // The popped head is the only entry lost; count is unchanged.
            head_d = head_q + PtrW'(1);
         end else if (full) begin
            head_d = head_q + PtrW'(1);
            ovf_d  = 1'b1;
         end else begin
            count_d = count_q + CntW'(1);
         end
      end else if (do_pop) begin
         head_d  = head_q + PtrW'(1);
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         nonempty_q <= 1'b0;
      end else begin
         // When full, tail == head, so this overwrites the dropped/popped entry.
         if (push_i) mem_q[tail_q] <= data_i;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         nonempty_q <= (count_d != '0);
      end
   end

   assign head_o     = mem_q[head_q];
   assign count_o    = count_q;
   assign full_o     = full;
   assign overflow_o = ovf_q;
   assign nonempty_o = nonempty_q;

endmodule

// File: rtl/core_cp15_fault_log.sv
// CP15 fault status/address registers with a fault history FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; transfer_i/load_i/sel_i/
// write_i CP15 MRC/MCR access (sel 0 FSR, 1 FAR, 2 LOGADDR, 3 LOGSTAT);
// fault_register_i with fault_addr_i/status/domain/prefetch captures a fault;
// read_o is the combinational read of the selected register; log_pending_o is
// the registered history-non-empty level.
// Optional macro CP15_FAULT_IFAR_EN: adds IFAR at sel 2 (prefetch faults update
// IFAR instead of FAR) and reads the log address as a second read of sel 3.
module core_cp15_fault_log
   import core_cp15_fault_log_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned STATUS_W = 4,
   parameter int unsigned DOMAIN_W = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                transfer_i,
   input  logic                load_i,
   input  logic [1:0]          sel_i,
   input  logic [31:0]         write_i,
   input  logic                fault_register_i,
   input  logic [29:0]         fault_addr_i,
   input  logic [STATUS_W-1:0] fault_status_i,
   input  logic [DOMAIN_W-1:0] fault_domain_i,
   input  logic                fault_prefetch_i,
   output logic [31:0]         read_o,
   output logic                log_pending_o
);

   localparam int unsigned FsrW = DOMAIN_W + STATUS_W;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [FsrW-1:0] fsr_q, fsr_d;
   logic [31:0]     far_q, far_d;
   logic            mcr;
   logic            pop, clr_ovf;
   fault_rec_t      push_rec, head_rec;
   logic [RecW-1:0] head_raw;
   logic [CntW-1:0] count;
   logic            fifo_full, overflow, valid;
   logic [31:0]     log_addr, log_stat;
   logic            far_capture;

   assign mcr     = transfer_i && !load_i;
   assign pop     = mcr && (sel_i == SelLogStat) && write_i[PopBit];
   assign clr_ovf = mcr && (sel_i == SelLogStat) && write_i[ClrOvfBit];

   assign push_rec.addr     = fault_addr_i;
   assign push_rec.status   = RecStatusW'(fault_status_i);
   assign push_rec.domain   = RecDomainW'(fault_domain_i);
   assign push_rec.prefetch = fault_prefetch_i;

`ifdef CP15_FAULT_IFAR_EN
   logic [31:0] ifar_q, ifar_d;
   logic        addr_next_q;
   logic        stat_mrc;

   assign far_capture = fault_register_i && !fault_prefetch_i;
   assign stat_mrc    = transfer_i && load_i && (sel_i == SelLogStat);

   always_comb begin
      ifar_d = ifar_q;
      if (fault_register_i && fault_prefetch_i) ifar_d = {fault_addr_i, 2'b00};
      else if (!fault_register_i && mcr && (sel_i == SelLogAddr)) ifar_d = write_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ifar_q      <= '0;
         addr_next_q <= 1'b0;
      end else begin
         ifar_q <= ifar_d;
         if (stat_mrc) addr_next_q <= !addr_next_q;
      end
   end
`else
   assign far_capture = fault_register_i;
`endif

   // Fault capture beats a same-cycle MCR to FSR/FAR.
   always_comb begin
      fsr_d = fsr_q;
      far_d = far_q;
      if (fault_register_i) fsr_d = {fault_domain_i, fault_status_i};
      else if (mcr && (sel_i == SelFsr)) fsr_d = write_i[FsrW-1:0];
      if (far_capture) far_d = {fault_addr_i, 2'b00};
      else if (!fault_register_i && mcr && (sel_i == SelFar)) far_d = write_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsr_q <= '0;
         far_q <= '0;
      end else begin
         fsr_q <= fsr_d;
         far_q <= far_d;
      end
   end

   core_cp15_fault_fifo #(
      .Depth (DEPTH),
      .Width (RecW)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (fault_register_i),
      .pop_i      (pop),
      .clr_ovf_i  (clr_ovf),
      .data_i     (push_rec),
      .head_o     (head_raw),
      .count_o    (count),
      .full_o     (fifo_full),
      .overflow_o (overflow),
      .nonempty_o (log_pending_o)
   );

   assign head_rec = fault_rec_t'(head_raw);
   assign valid    = (count != '0);

   always_comb begin
      log_addr = '0;
      log_stat = '0;
      log_stat[LsValidBit]                 = valid;
      log_stat[LsOvfBit]                   = overflow;
      log_stat[LsCountLsb+:8]              = 8'(count);
      if (valid) begin
         log_addr                          = {head_rec.addr, 2'b00};
         log_stat[LsPrefetchBit]           = head_rec.prefetch;
         log_stat[LsDomainLsb+:RecDomainW] = head_rec.domain;
         log_stat[LsStatusLsb+:RecStatusW] = head_rec.status;
      end
   end

   always_comb begin
      read_o = '0;
      case (sel_i)
         SelFsr:     read_o = 32'(fsr_q);
         SelFar:     read_o = far_q;
`ifdef CP15_FAULT_IFAR_EN
         SelLogAddr: read_o = ifar_q;
         default: begin
            if (addr_next_q) begin
               read_o = log_addr;
            end else begin
               read_o                = log_stat;
               read_o[LsAddrNextBit] = 1'b1;
            end
         end
`else
         SelLogAddr: read_o = log_addr;
         default:    read_o = log_stat;
`endif
      endcase
   end

   // Full flag is available for debug taps; not part of the CP15 read map.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_core_cp15_fault_log.sv
module tb_core_cp15_fault_log;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        transfer = 1'b0;
   logic        load = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [31:0] write = '0;
   logic        fault_register = 1'b0;
   logic [29:0] fault_addr = '0;
   logic [3:0]  fault_status = '0;
   logic [3:0]  fault_domain = '0;
   logic        fault_prefetch = 1'b0;
   logic [31:0] read;
   logic        log_pending;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   core_cp15_fault_log #(
      .DEPTH    (4),
      .STATUS_W (4),
      .DOMAIN_W (4)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .transfer_i       (transfer),
      .load_i           (load),
      .sel_i            (sel),
      .write_i          (write),
      .fault_register_i (fault_register),
      .fault_addr_i     (fault_addr),
      .fault_status_i   (fault_status),
      .fault_domain_i   (fault_domain),
      .fault_prefetch_i (fault_prefetch),
      .read_o           (read),
      .log_pending_o    (log_pending)
   );

   // One clock edge applies the driven strobes; they are then released.
   task automatic tick();
      @(posedge clk);
      #1;
      fault_register = 1'b0;
      transfer       = 1'b0;
      load           = 1'b0;
      write          = '0;
   endtask

   task automatic set_fault(input logic [29:0] a, input logic [3:0] st,
                            input logic [3:0] dom, input logic pf);
      fault_register = 1'b1;
      fault_addr     = a;
      fault_status   = st;
      fault_domain   = dom;
      fault_prefetch = pf;
   endtask

   task automatic set_mcr(input logic [1:0] s, input logic [31:0] d);
      transfer = 1'b1;
      load     = 1'b0;
      sel      = s;
      write    = d;
   endtask

   task automatic expect_rd(input string name, input logic [1:0] s, input logic [31:0] v);
      sb.push_back('{name, s, v});
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #7;
      expect_rd("reset_fsr", 2'd0, 32'h0);
      expect_rd("reset_far", 2'd1, 32'h0);
      expect_rd("reset_logaddr", 2'd2, 32'h0);
      expect_rd("reset_logstat", 2'd3, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      n_run++;
      if (log_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pending: got %b expected 0", log_pending);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_capture();
      apply_reset();
      set_fault(30'h0000_1234, 4'd5, 4'd3, 1'b0);
      tick();
      n_run++;
      if (log_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL capture_pending: got %b expected 1", log_pending);
      end
      expect_rd("capture_far", 2'd1, 32'h0000_48D0);
      expect_rd("capture_fsr", 2'd0, 32'h0000_0035);
      expect_rd("capture_logstat", 2'd3, 32'h8001_0035);
      expect_rd("capture_logaddr", 2'd2, 32'h0000_48D0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      set_mcr(2'd3, 32'h1);
      tick();
      n_run++;
      if (log_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_pending: got %b expected 0", log_pending);
      end
      expect_rd("drain_logstat", 2'd3, 32'h0);
      expect_rd("drain_logaddr", 2'd2, 32'h0);
      expect_rd("drain_far_kept", 2'd1, 32'h0000_48D0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 1; i <= 5; i++) begin
         set_fault(30'(i), 4'd0, 4'd0, 1'b0);
         tick();
      end
      expect_rd("ovf_logstat", 2'd3, 32'hC004_0000);
      expect_rd("ovf_logaddr", 2'd2, 32'h0000_0008);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      set_mcr(2'd3, 32'h3);
      tick();
      expect_rd("popclr_logaddr", 2'd2, 32'h0000_000C);
      expect_rd("popclr_logstat", 2'd3, 32'h8003_0000);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
   endtask

   task automatic test_mcr_conflict();
      apply_reset();
      set_fault(30'h0000_0010, 4'd2, 4'd1, 1'b0);
      set_mcr(2'd1, 32'hDEAD_BEEF);
      tick();
      expect_rd("conflict_far", 2'd1, 32'h0000_0040);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      set_mcr(2'd1, 32'hDEAD_BEEF);
      tick();
      set_mcr(2'd0, 32'hFFFF_FFA7);
      tick();
      set_mcr(2'd2, 32'h1234_5678);
      tick();
      expect_rd("mcr_far", 2'd1, 32'hDEAD_BEEF);
      expect_rd("mcr_fsr", 2'd0, 32'h0000_00A7);
      expect_rd("mcr_logaddr_ignored", 2'd2, 32'h0000_0040);
      expect_rd("mcr_logstat_kept", 2'd3, 32'h8001_0012);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         set_fault(30'(i), 4'd0, 4'd0, 1'b0);
         tick();
      end
      set_fault(30'd9, 4'd0, 4'd0, 1'b0);
      set_mcr(2'd3, 32'h1);
      tick();
      expect_rd("fullpp_logstat", 2'd3, 32'h8004_0000);
      expect_rd("fullpp_logaddr", 2'd2, 32'h0000_0008);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      for (int i = 0; i < 3; i++) begin
         set_mcr(2'd3, 32'h1);
         tick();
      end
      expect_rd("fullpp_tail_addr", 2'd2, 32'h0000_0024);
      expect_rd("fullpp_tail_stat", 2'd3, 32'h8001_0000);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      // Overflow raised by a fault beats a same-cycle clear.
      for (int i = 0; i < 4; i++) begin
         set_fault(30'(16 + i), 4'd0, 4'd0, 1'b0);
         tick();
      end
      set_fault(30'd32, 4'd0, 4'd0, 1'b0);
      set_mcr(2'd3, 32'h2);
      tick();
      expect_rd("ovf_vs_clear", 2'd3, 32'hC004_0000);
      expect_rd("ovf_vs_clear_head", 2'd2, 32'h0000_0044);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
   endtask

   task automatic test_pop_empty();
      apply_reset();
      set_mcr(2'd3, 32'h1);
      tick();
      set_mcr(2'd3, 32'h1);
      tick();
      expect_rd("popempty_logstat", 2'd3, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      set_fault(30'h0000_0077, 4'hA, 4'h1, 1'b1);
      tick();
      set_fault(30'h0000_0055, 4'h3, 4'h2, 1'b0);
      tick();
      expect_rd("popempty_logstat2", 2'd3, 32'h8002_011A);
      expect_rd("popempty_logaddr2", 2'd2, 32'h0000_01DC);
      expect_rd("popempty_far", 2'd1, 32'h0000_0154);
      expect_rd("popempty_fsr", 2'd0, 32'h0000_0023);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         set_fault(30'(100 + i), 4'd7, 4'd7, 1'b0);
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if (log_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_pending: got %b expected 0", log_pending);
      end
      expect_rd("areset_fsr", 2'd0, 32'h0);
      expect_rd("areset_far", 2'd1, 32'h0);
      expect_rd("areset_logstat", 2'd3, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
      rst_n = 1'b1;
      tick();
      expect_rd("areset_after_logaddr", 2'd2, 32'h0);
      expect_rd("areset_after_logstat", 2'd3, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); sel = e.sel; #1;
         n_run++;
         if (read !== e.val) begin
            n_fail++;
            $display("FAIL %s: read=%h expected=%h", e.name, read, e.val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_overflow();
      test_mcr_conflict();
      test_back_to_back();
      test_pop_empty();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/core_cp15_fault_log.md
Name: core_cp15_fault_log

Overview:
- Parametrised successor to the CP15 fault address register.
- Keeps the architected c5 FSR and c6 FAR: the most recent fault, writable by MCR.
- Adds a DEPTH-entry FIFO history of fault records (address, status, domain, prefetch flag). Software drains it through CP15 transfers.
- Sits in the CP15 register file. The MMU/abort path feeds it; the coprocessor transfer mux reads it.

Parameters:
- DEPTH, 4: history FIFO entries. Power of two, ≥2.
- STATUS_W, 4: fault status field width (FSR[3:0]).
- DOMAIN_W, 4: domain field width (FSR[7:4]).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- transfer  in  1  CP15 transfer targets this block this cycle
- load  in  1  1 = MRC (read), 0 = MCR (write); meaningful only with transfer
- sel  in  2  0 = FSR, 1 = FAR, 2 = LOGADDR, 3 = LOGSTAT
- write  in  32 (word)  MCR data
- fault_register  in  1  fault capture strobe, one cycle per fault
- fault_addr  in  30 (ptr)  faulting word address
- fault_status  in  STATUS_W  fault status code
- fault_domain  in  DOMAIN_W  faulting domain
- fault_prefetch  in  1  fault came from instruction fetch
- read  out  32  selected register, combinational
- log_pending  out  1  history non-empty (registered level)

Behaviour:
- Reset:
  - fsr, far, all FIFO storage, pointers, count and overflow clear to 0.
  - read = 0 for every sel; log_pending = 0.
- Fault capture (fault_register = 1), all updates at the next clk edge:
  - far <= {fault_addr, 2'b00}.
  - fsr <= {fault_domain, fault_status}, zero-extended.
  - Record is pushed at the tail.
- FIFO full on capture:
  - Oldest entry is dropped: head advances together with the tail.
  - count stays DEPTH; overflow sets sticky.
- MCR (transfer && !load):
  - sel 0: fsr <= write[DOMAIN_W+STATUS_W-1:0].
  - sel 1: far <= write.
  - sel 2: ignored.
  - sel 3 with write[0] = 1: pops head if count > 0; no effect when empty.
  - sel 3 with write[1] = 1: clears overflow.
  - Both bits may be set in one write.
- Same cycle as fault_register:
  - An MCR to sel 0 or 1 loses; fault data wins.
  - A pop still takes effect. Push+pop leaves count unchanged; if full, only one entry is dropped (the popped head).
  - Overflow set by the fault wins over a same-cycle clear.
- Read values (any cycle, independent of transfer/load):
  - sel 0: fsr. sel 1: far. Both are zero-extended where narrower than 32 bits.
  - sel 2: head {addr, 2'b00}, or 0 when empty.
  - sel 3: [31] = valid (count ≠ 0), [30] = overflow, [23:16] = count, [8] = head prefetch, [7:4] = head domain, [3:0] = head status. Head fields read 0 when empty; other bits 0.
- Pointers and count:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits; it never exceeds DEPTH and never underflows.
- Timing:
  - log_pending = (count ≠ 0), registered: it reflects a push one cycle after the strobe.
  - A capture is visible on read the cycle after the strobe; a pop likewise.
- Async reset mid-operation discards all history; no partial updates survive.

Optional Feature:
- Macro: CP15_FAULT_IFAR_EN.
- When defined:
  - Adds a separate IFAR register.
  - Prefetch faults update ifar instead of far; fsr and the FIFO push still occur.
  - sel 2 becomes IFAR (read, and MCR write).
  - Log address moves to sel 3 bits replaced by a 2-step read: LOGSTAT[29] = 1 means the next read of sel 3 returns the address. This is a one-bit toggle state, reset 0, advanced by each MRC of sel 3.
- When undefined: no IFAR; behaviour is exactly as above.

Decomposition:
- Shared package (core/cp15 map header):
  - Fault record struct: addr ptr, status, domain, prefetch.
  - Register-select constants: FSR, FAR, LOGADDR, LOGSTAT.
  - LOGSTAT bit positions.
  - Pop and clear bit indices.
- One sub-module, core_cp15_fault_fifo:
  - Generic DEPTH-entry overwrite-oldest FIFO with push, pop, full, count and overflow.
  - Instantiated once.

Test Plan:
- Reset, then reads of sel 0–3 -> all 0; log_pending 0.
- Fault addr = 30'h0000_1234, status = 5, domain = 3 -> next cycle: FAR = 0x000048D0, FSR = 0x35, LOGSTAT = 0x80010035, LOGADDR = 0x000048D0, log_pending 1.
- Five faults with addr 1..5, DEPTH = 4 -> LOGSTAT count = 4 and overflow = 1; LOGADDR = 0x8. MCR sel 3 = 0x3 -> head addr 0xC, count 3, overflow 0.
- Fault plus same-cycle MCR sel 1 = 0xDEADBEEF -> FAR holds the fault address. A later MCR alone -> FAR = 0xDEADBEEF.
- Full FIFO, fault plus pop in the same cycle -> count stays 4; head advances exactly one entry.
- Pop when empty -> count 0, no pointer change; a subsequent fault reads back correctly.
